// File: rtl/aes_dec_arbiter.sv
//==============================================================================
// Module   : aes_dec_arbiter
// Purpose  : Two-requester round-robin arbiter in front of one shared AES
//            decrypt core; one block in flight, response returned to its owner.
//            Optional completion counters enabled by AES_DEC_ARB_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_dec_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [127:0]     s0_data,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [127:0]     s1_data,
    output logic             m0_valid,
    input  logic             m0_ready,
    output logic             m1_valid,
    input  logic             m1_ready,
    output logic [127:0]     m_data,
    output logic             core_start,
    input  logic             core_ready,
    output logic [127:0]     core_ciphertext,
    input  logic             core_done,
    input  logic [127:0]     core_plaintext,
    output logic             core_unpack_ready,
    output logic             busy
`ifdef AES_DEC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_rr;
    logic         r_owner;
    logic [127:0] r_ct;
    logic [127:0] r_pt;

    logic         w_grant;
    logic         w_accept;
    logic         w_resp_hs;

    generate
        if (CNT_W < 1) begin : g_cnt_w_bad
            $error("aes_dec_arbiter: CNT_W must be at least 1");
        end
    endgenerate

    // Grant: a lone requester wins; a tie is settled by the round-robin pointer.
    always_comb begin
        w_grant = 1'b0;
        if (s0_valid && s1_valid) begin
            w_grant = r_rr;
        end else if (s1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Reset gates acceptance so the ready outputs read zero while reset is held.
    assign w_accept  = (r_state == ST_IDLE) && core_ready && (s0_valid || s1_valid) && !reset;
    assign w_resp_hs = (r_state == ST_RESP) && (r_owner ? m1_ready : m0_ready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)  w_state_nxt = ST_ISSUE;
            ST_ISSUE:                w_state_nxt = ST_WAIT;
            ST_WAIT:  if (core_done) w_state_nxt = ST_RESP;
            ST_RESP:  if (w_resp_hs) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rr    <= 1'b0;
            r_owner <= 1'b0;
            r_ct    <= '0;
            r_pt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ct    <= w_grant ? s1_data : s0_data;
                r_owner <= w_grant;
            end
            if ((r_state == ST_WAIT) && core_done) begin
                r_pt <= core_plaintext;
            end
            if (w_resp_hs) begin
                r_rr <= ~r_owner;
            end
        end
    end

    assign s0_ready          = w_accept && !w_grant;
    assign s1_ready          = w_accept &&  w_grant;
    assign m0_valid          = (r_state == ST_RESP) && !r_owner;
    assign m1_valid          = (r_state == ST_RESP) &&  r_owner;
    assign m_data            = r_pt;
    assign core_start        = (r_state == ST_ISSUE);
    assign core_ciphertext   = r_ct;
    assign core_unpack_ready = (r_state == ST_WAIT);
    assign busy              = (r_state != ST_IDLE);

`ifdef AES_DEC_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Completion counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (m0_valid && m0_ready && (r_cnt0 != {CNT_W{1'b1}})) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (m1_valid && m1_ready && (r_cnt1 != {CNT_W{1'b1}})) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

`default_nettype wire
